mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported memory bus between instruction fetch (IF) and the MEM-stage data access driven from the EX/MEM register outputs.
- Sequences one outstanding bus transaction at a time and handles wait states and bus timeout.
- Generates the 6-bit pipeline stall vector consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Parameters:
ADDR_WIDTH, 32, bus and request address width
DATA_WIDTH, 32, bus and request data width
MASK_WIDTH, 2, access-size mask width; value passed through unchanged
TIMEOUT, 16, cycles in a bus wait state before forced completion (>=2)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
if_req  in  1  IF fetch request, held until if_valid
if_addr  in  ADDR_WIDTH  fetch address
if_rdata  out  DATA_WIDTH  fetched instruction, registered
if_valid  out  1  one-cycle fetch-complete pulse
mem_read_mem  in  1  MEM-stage load request
mem_write_mem  in  1  MEM-stage store request
alu_res_mem  in  ADDR_WIDTH  data address
bypass_op2_mem  in  DATA_WIDTH  store data
mask_mem  in  MASK_WIDTH  access size
mem_rdata  out  DATA_WIDTH  load data, registered, held until next data completion
mem_done  out  1  one-cycle data-complete pulse
bus_req  out  1  bus request, registered
bus_we  out  1  write enable, registered
bus_addr  out  ADDR_WIDTH  registered address
bus_wdata  out  DATA_WIDTH  registered write data
bus_mask  out  MASK_WIDTH  registered mask
bus_ack  in  1  bus completion; bus_rdata valid in the same cycle
bus_rdata  in  DATA_WIDTH  bus read data
bus_err  out  1  sticky timeout flag
stall  out  6  [0] PC, [1] IF, [2] ID, [3] EX, [4] MEM, [5] WB (always 0)

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. All outputs are 0, including bus_req, bus_err, if_valid, mem_done, if_rdata, mem_rdata and the timeout counter.
- Reset mid-transaction: bus_req drops immediately and the pending transaction is abandoned. bus_ack arriving while in reset or in IDLE is ignored.
- dreq = mem_read_mem | mem_write_mem. If both bits are set, the access is a write.
- FSM states: IDLE, DATA, INST, RESP_D, RESP_I.
- IDLE:
  - If dreq: latch alu_res_mem, bypass_op2_mem, mask_mem and we=mem_write_mem into the bus_* registers, set bus_req=1, go to DATA.
  - Else if if_req: latch if_addr, set bus_we=0, bus_req=1, go to INST.
  - Data has priority over fetch.
- DATA / INST:
  - Hold every bus_* output stable and increment the wait counter.
  - On bus_ack: bus_req=0 and counter=0. From DATA, mem_rdata<=bus_rdata (loads only; stores leave mem_rdata unchanged) and go to RESP_D. From INST, if_rdata<=bus_rdata and go to RESP_I.
  - If the counter reaches TIMEOUT-1 without bus_ack: complete as above with read data 0 and set bus_err=1 (sticky until reset).
  - An ack in the same cycle as the timeout counts as a normal completion.
- RESP_D: mem_done=1 for this cycle, then go to IDLE. Requests are ignored this cycle, because EX/MEM still presents the same instruction and it must not be reissued.
- RESP_I: if_valid=1 for this cycle, then go to IDLE. Requests are ignored this cycle.
- No preemption: a data request arriving during INST waits for the fetch to finish.
- Latency: data or fetch takes 1 (issue) + N (cycles until ack, N>=1) + 1 (response) cycles. Minimum is 3 cycles with an immediate ack.
- Stall, combinational from state and requests:
  - d = dreq & (state != RESP_D).
  - f = if_req & (state != RESP_I).
  - stall = {1'b0, d, d, d, d|f, d|f}.
  - With only a fetch pending, stall = 6'b000011 (bubble into ID).
  - With a data access pending, stall = 6'b011111.
  - In RESP_D with no fetch pending, stall = 0.

Test Plan:
- Load alone: mem_read_mem=1, alu_res_mem=0x100, bus acks 2 cycles after bus_req with bus_rdata=0xDEADBEEF -> bus_req high 2 cycles, bus_addr=0x100, bus_we=0; mem_done pulses with mem_rdata=0xDEADBEEF; stall=6'b011111 until the RESP_D cycle, then 0.
- Store: mem_write_mem=1, addr 0x204, data 0x12345678, mask 2'b10 -> bus_we=1 with those values held stable until ack; mem_rdata unchanged; mem_done pulses.
- Contention: if_req and mem_read_mem both rise in IDLE -> data is served first, then fetch. During RESP_D with if_req still high, stall=6'b000011. if_valid follows 3 cycles later with an immediate ack.
- Fetch then data: a data request arrives in INST cycle 1 -> fetch completes first (if_valid), then data issues; stall stays 6'b011111 throughout.
- Timeout: TIMEOUT=16, no ack -> bus_req drops after 16 cycles, mem_rdata=0, mem_done pulses, bus_err=1 and remains 1 after later successful accesses.
- Reset mid-DATA: rst=0 asserted asynchronously mid-cycle -> bus_req and stall go to 0 immediately. After release, a re-presented load reissues cleanly and a stale ack during reset has no effect.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported memory bus between instruction fetch and MEM-stage data access.
// One transaction at a time, with wait states, a bus timeout and pipeline stall generation.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MASK_WIDTH = 2,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_valid,
    input  logic                  mem_read_mem,
    input  logic                  mem_write_mem,
    input  logic [ADDR_WIDTH-1:0] alu_res_mem,
    input  logic [DATA_WIDTH-1:0] bypass_op2_mem,
    input  logic [MASK_WIDTH-1:0] mask_mem,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_done,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    output logic [MASK_WIDTH-1:0] bus_mask,
    input  logic                  bus_ack,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    output logic                  bus_err,
    output logic [5:0]            stall
);

    localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StData,
        StInst,
        StRespD,
        StRespI
    } state_t;

    state_t               state_q;
    logic [CNT_WIDTH-1:0] wait_cnt_q;
    logic                 dreq;
    logic                 timed_out;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                 stall_d;
    logic                 stall_f;

    assign dreq      = mem_read_mem | mem_write_mem;
    assign timed_out = (wait_cnt_q == CNT_LAST);
    // An ack coinciding with the timeout is a normal completion.
    assign resp_data = bus_ack ? bus_rdata : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            if_rdata   <= '0;
            if_valid   <= 1'b0;
            mem_rdata  <= '0;
            mem_done   <= 1'b0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_mask   <= '0;
            bus_err    <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            mem_done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    wait_cnt_q <= '0;
                    if (dreq) begin
                        bus_addr  <= alu_res_mem;
                        bus_wdata <= bypass_op2_mem;
                        bus_mask  <= mask_mem;
                        bus_we    <= mem_write_mem;
                        bus_req   <= 1'b1;
                        state_q   <= StData;
                    end else if (if_req) begin
                        bus_addr <= if_addr;
                        bus_we   <= 1'b0;
                        bus_req  <= 1'b1;
                        state_q  <= StInst;
                    end
                end
                StData, StInst: begin
                    if (bus_ack || timed_out) begin
                        bus_req    <= 1'b0;
                        wait_cnt_q <= '0;
                        if (!bus_ack) begin
                            bus_err <= 1'b1;
                        end
                        if (state_q == StData) begin
                            // Stores leave the last load result visible.
                            if (!bus_we) begin
                                mem_rdata <= resp_data;
                            end
                            mem_done <= 1'b1;
                            state_q  <= StRespD;
                        end else begin
                            if_rdata <= resp_data;
                            if_valid <= 1'b1;
                            state_q  <= StRespI;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_WIDTH'(1);
                    end
                end
                StRespD, StRespI: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // The response cycle releases its own requester: EX/MEM or IF still shows the finished request.
    always_comb begin
        stall_d = dreq & (state_q != StRespD);
        stall_f = if_req & (state_q != StRespI);
        stall   = '0;
        if (rst) begin
            stall = {1'b0, stall_d, stall_d, stall_d, stall_d | stall_f, stall_d | stall_f};
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios push expected bus transactions and
// responses; a bus responder and a response monitor compare independently.
module tb_mem_port_arbiter;

    localparam int unsigned TIMEOUT = 16;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        mem_read_mem;
    logic        mem_write_mem;
    logic [31:0] alu_res_mem;
    logic [31:0] bypass_op2_mem;
    logic [1:0]  mask_mem;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [1:0]  bus_mask;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;
    logic [5:0]  stall;

    mem_port_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .MASK_WIDTH(2),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_rdata      (if_rdata),
        .if_valid      (if_valid),
        .mem_read_mem  (mem_read_mem),
        .mem_write_mem (mem_write_mem),
        .alu_res_mem   (alu_res_mem),
        .bypass_op2_mem(bypass_op2_mem),
        .mask_mem      (mask_mem),
        .mem_rdata     (mem_rdata),
        .mem_done      (mem_done),
        .bus_req       (bus_req),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_mask      (bus_mask),
        .bus_ack       (bus_ack),
        .bus_rdata     (bus_rdata),
        .bus_err       (bus_err),
        .stall         (stall)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [1:0]  mask;
        int          delay;   // 0: never ack
        logic [31:0] rdata;
        bit          abandon; // cut short by reset
    } bus_txn_t;

    typedef struct {
        bit          is_data;
        logic [31:0] data;
        logic        err;
    } resp_t;

    bus_txn_t bus_q[$];
    resp_t    resp_q[$];

    int checks = 0;
    int errors = 0;

    logic [31:0] model_rdata = '0;
    logic [31:0] model_wdata = '0;
    logic [1:0]  model_mask  = '0;
    logic        model_err   = 1'b0;

    bit          man_en    = 1'b0;
    logic [31:0] man_rdata = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bus responder: checks the issued transaction, holds it, acks after the programmed delay.
    bus_txn_t cur;
    bit       in_txn = 1'b0;
    int       hi_cnt = 0;
    always @(negedge clk) begin
        if (man_en) begin
            bus_ack   = 1'b1;
            bus_rdata = man_rdata;
        end else if (bus_req) begin
            if (!in_txn) begin
                if (bus_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bus_unexpected: got addr 0x%08h expected no transaction", bus_addr);
                    cur.addr = bus_addr; cur.we = bus_we; cur.wdata = bus_wdata;
                    cur.mask = bus_mask; cur.delay = 1; cur.rdata = '0; cur.abandon = 1'b1;
                end else begin
                    cur = bus_q.pop_front();
                end
                in_txn = 1'b1;
                hi_cnt = 0;
            end
            check("bus_addr", bus_addr, cur.addr);
            check("bus_we", {31'b0, bus_we}, {31'b0, cur.we});
            check("bus_wdata", bus_wdata, cur.wdata);
            check("bus_mask", {30'b0, bus_mask}, {30'b0, cur.mask});
            hi_cnt++;
            bus_ack   = (cur.delay != 0) && (hi_cnt == cur.delay);
            bus_rdata = bus_ack ? cur.rdata : 32'h0;
        end else begin
            if (in_txn && !cur.abandon) begin
                check("bus_req_len", hi_cnt, (cur.delay == 0) ? TIMEOUT : cur.delay);
            end
            in_txn    = 1'b0;
            bus_ack   = 1'b0;
            bus_rdata = 32'h0;
        end
    end

    // Response monitor: every completion pulse must match the next expected response.
    always @(negedge clk) begin
        if (mem_done || if_valid) begin
            if (resp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_unexpected: got done=%0b valid=%0b expected none", mem_done,
                         if_valid);
            end else begin
                resp_t r;
                r = resp_q.pop_front();
                check("resp_kind", {31'b0, mem_done}, {31'b0, r.is_data});
                check("resp_kind_if", {31'b0, if_valid}, {31'b0, !r.is_data});
                check(r.is_data ? "mem_rdata" : "if_rdata", r.is_data ? mem_rdata : if_rdata, r.data);
                check("bus_err", {31'b0, bus_err}, {31'b0, r.err});
            end
        end
    end

    task automatic push_bus(input logic [31:0] addr, input logic we, input int delay,
                            input logic [31:0] rdata, input bit abandon);
        bus_txn_t t;
        t.addr = addr; t.we = we; t.wdata = model_wdata; t.mask = model_mask;
        t.delay = delay; t.rdata = rdata; t.abandon = abandon;
        bus_q.push_back(t);
    endtask

    task automatic expect_data(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [1:0] mask, input int delay,
                               input logic [31:0] rdata);
        resp_t r;
        model_wdata = wdata;
        model_mask  = mask;
        push_bus(addr, wr, delay, rdata, 1'b0);
        if (!wr && rd) model_rdata = (delay == 0) ? 32'h0 : rdata;
        if (delay == 0) model_err = 1'b1;
        r.is_data = 1'b1; r.data = model_rdata; r.err = model_err;
        resp_q.push_back(r);
    endtask

    task automatic expect_fetch(input logic [31:0] addr, input int delay, input logic [31:0] rdata);
        resp_t r;
        push_bus(addr, 1'b0, delay, rdata, 1'b0);
        if (delay == 0) model_err = 1'b1;
        r.is_data = 1'b0; r.data = (delay == 0) ? 32'h0 : rdata; r.err = model_err;
        resp_q.push_back(r);
    endtask

    task automatic drive_data(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] mask);
        mem_read_mem = rd; mem_write_mem = wr; alu_res_mem = addr;
        bypass_op2_mem = wdata; mask_mem = mask;
    endtask

    task automatic do_data(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] mask, input int delay,
                           input logic [31:0] rdata);
        int n;
        expect_data(rd, wr, addr, wdata, mask, delay, rdata);
        drive_data(rd, wr, addr, wdata, mask);
        #1;
        n = 0;
        while (!mem_done && n < 60) begin
            check("stall_data_pending", {26'b0, stall}, 32'h1F);
            step();
            #1;
            n++;
        end
        check("data_latency", n, ((delay == 0) ? TIMEOUT : delay) + 1);
        check("stall_resp_d", {26'b0, stall}, if_req ? 32'h03 : 32'h00);
        check("bus_req_resp_d", {31'b0, bus_req}, 32'h0);
        drive_data(1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
        step();
    endtask

    task automatic do_fetch(input logic [31:0] addr, input int delay, input logic [31:0] rdata);
        int n;
        expect_fetch(addr, delay, rdata);
        if_req = 1'b1; if_addr = addr;
        #1;
        n = 0;
        while (!if_valid && n < 60) begin
            check("stall_fetch_pending", {26'b0, stall}, 32'h03);
            step();
            #1;
            n++;
        end
        check("fetch_latency", n, ((delay == 0) ? TIMEOUT : delay) + 1);
        check("stall_resp_i", {26'b0, stall}, 32'h00);
        if_req = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b0; if_req = 1'b0; if_addr = '0;
        drive_data(1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
        #12;
        check("rst_bus_req", {31'b0, bus_req}, 32'h0);
        check("rst_bus_err", {31'b0, bus_err}, 32'h0);
        check("rst_if_valid", {31'b0, if_valid}, 32'h0);
        check("rst_mem_done", {31'b0, mem_done}, 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_mem_rdata", mem_rdata, 32'h0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_stall", {26'b0, stall}, 32'h0);
        #11;
        rst = 1'b1;
        step();

        // Load, ack after 2 bus cycles.
        do_data(1'b1, 1'b0, 32'h100, 32'h0, 2'b00, 2, 32'hDEADBEEF);
        // Store keeps the previous load data.
        do_data(1'b0, 1'b1, 32'h204, 32'h12345678, 2'b10, 3, 32'hFFFFFFFF);
        // Fetch alone, immediate ack.
        do_fetch(32'h40, 1, 32'h00000013);
        // Read and write together is a write.
        do_data(1'b1, 1'b1, 32'h208, 32'hA5A5A5A5, 2'b01, 1, 32'h11111111);

        // Contention: data first, fetch follows.
        expect_data(1'b1, 1'b0, 32'h110, 32'h0, 2'b00, 2, 32'h0BADCAFE);
        expect_fetch(32'h44, 1, 32'h00100093);
        if_req = 1'b1; if_addr = 32'h44;
        drive_data(1'b1, 1'b0, 32'h110, 32'h0, 2'b00);
        #1;
        n = 0;
        while (!mem_done && n < 40) begin
            check("stall_contend_data", {26'b0, stall}, 32'h1F);
            step(); #1; n++;
        end
        check("contend_data_latency", n, 3);
        check("stall_contend_resp_d", {26'b0, stall}, 32'h03);
        drive_data(1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
        n = 0;
        do begin
            step(); #1; n++;
            if (!if_valid) check("stall_contend_fetch", {26'b0, stall}, 32'h03);
        end while (!if_valid && n < 40);
        check("contend_fetch_latency", n, 3);
        check("stall_contend_resp_i", {26'b0, stall}, 32'h00);
        if_req = 1'b0;
        step();

        // Data arrives during a fetch: no preemption.
        expect_fetch(32'h48, 2, 32'hFFC10113);
        expect_data(1'b1, 1'b0, 32'h118, 32'h0, 2'b00, 1, 32'h76543210);
        if_req = 1'b1; if_addr = 32'h48;
        #1;
        check("stall_fd_idle", {26'b0, stall}, 32'h03);
        step();
        drive_data(1'b1, 1'b0, 32'h118, 32'h0, 2'b00);
        #1;
        n = 1;
        while (!if_valid && n < 40) begin
            check("stall_fd_inst", {26'b0, stall}, 32'h1F);
            step(); #1; n++;
        end
        check("fd_fetch_latency", n, 3);
        check("stall_fd_resp_i", {26'b0, stall}, 32'h1F);
        if_req = 1'b0;
        n = 0;
        do begin
            step(); #1; n++;
            if (!mem_done) check("stall_fd_data", {26'b0, stall}, 32'h1F);
        end while (!mem_done && n < 40);
        check("fd_data_latency", n, 3);
        check("stall_fd_resp_d", {26'b0, stall}, 32'h00);
        drive_data(1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
        step();

        // Timeout, then a good access with the error flag still set.
        do_data(1'b1, 1'b0, 32'h2F0, 32'h0, 2'b00, 0, 32'h0);
        do_data(1'b1, 1'b0, 32'h2F4, 32'h0, 2'b00, 1, 32'h55AA55AA);

        // Reset in the middle of a data wait; stale acks during and after reset.
        model_wdata = 32'h0; model_mask = 2'b00;
        push_bus(32'h300, 1'b0, 0, 32'h0, 1'b1);
        drive_data(1'b1, 1'b0, 32'h300, 32'h0, 2'b00);
        step();
        step();
        #2;
        rst = 1'b0; man_en = 1'b1; man_rdata = 32'hBADBAD00;
        #1;
        check("rst_mid_bus_req", {31'b0, bus_req}, 32'h0);
        check("rst_mid_stall", {26'b0, stall}, 32'h0);
        check("rst_mid_bus_err", {31'b0, bus_err}, 32'h0);
        check("rst_mid_mem_rdata", mem_rdata, 32'h0);
        repeat (2) @(posedge clk);
        #3;
        drive_data(1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
        rst = 1'b1;
        step();
        check("idle_ack_bus_req", {31'b0, bus_req}, 32'h0);
        check("idle_ack_mem_done", {31'b0, mem_done}, 32'h0);
        check("idle_ack_mem_rdata", mem_rdata, 32'h0);
        man_en = 1'b0;
        model_rdata = 32'h0; model_err = 1'b0;
        step();
        do_data(1'b1, 1'b0, 32'h300, 32'h0, 2'b00, 1, 32'hCAFEF00D);

        repeat (4) step();
        check("bus_q_empty", bus_q.size(), 0);
        check("resp_q_empty", resp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
